// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch responder.
//   pipe_tag_t : per-request tag carried down the SRAM latency pipe
//   rsp_t      : response payload held in the response FIFO
//   addr_legal : alignment + window check for a fetch PC
package imem_pkg;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  typedef struct packed {
    logic vld;
    logic err;
    logic hi;
  } pipe_tag_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  // 4-byte aligned and inside [base, base+size); the limit is formed in
  // 65 bits so a window touching the top of the address space cannot wrap.
  function automatic logic addr_legal(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] size);
    logic [64:0] limit;
    limit = {1'b0, base} + {1'b0, size};
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word.
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : write strobe and data (ignored when full without pop)
//   pop          : consume the head (ignored when empty)
//   rdata        : registered head; holds its last value when empty
//   full, empty  : occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] count_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] rd_nxt_idx_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Extra pointer MSB distinguishes full from empty.
  assign count_c      = wr_ptr_q - rd_ptr_q;
  assign full         = (count_c == PTR_W'(DEPTH));
  assign empty        = (count_c == '0);
  assign wr_idx_c     = wr_ptr_q[IDX_W-1:0];
  assign rd_idx_c     = rd_ptr_q[IDX_W-1:0];
  assign rd_nxt_idx_c = rd_idx_c + IDX_W'(1);
  assign push_ok_c    = push && (!full || pop);
  assign pop_ok_c     = pop && !empty;

  // Storage array, no reset needed: a slot is only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_idx_c] <= wdata;
    end
  end

  // Pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Head register tracks the next-cycle head; it bypasses the array when the
  // incoming word becomes the new head, and holds when the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (push_ok_c && (empty || (pop_ok_c && count_c == PTR_W'(1)))) begin
      rdata <= wdata;
    end else if (pop_ok_c && count_c > PTR_W'(1)) begin
      rdata <= mem_q[rd_nxt_idx_c];
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Memory-side responder for the fetch PC stream: accepts fetch PCs, reads a
// 64-bit SRAM with fixed latency and returns 32-bit instruction words in order.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : fetch request handshake, req_addr = fetch PC
//   mem_en/mem_addr     : SRAM read strobe and doubleword address
//   mem_rdata           : SRAM data, valid LATENCY cycles after mem_en
//   rsp_valid/rsp_ready : response handshake
//   rsp_inst/rsp_err    : instruction word and access-fault flag
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4,
  parameter logic [63:0] BASE    = PC_RESET,
  parameter logic [63:0] SIZE    = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        mem_en,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err
);

  localparam int unsigned CRED_W = $clog2(DEPTH) + 1;

  logic [CRED_W-1:0] credit_q;
  pipe_tag_t         pipe_q [LATENCY];
  pipe_tag_t         head_c;
  rsp_t              push_rsp_c;
  rsp_t              head_rsp;
  logic              accept_c;
  logic              legal_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;

  // Request side: credit covers both in-flight reads and FIFO occupancy.
  assign req_ready = rst_n && (credit_q < CRED_W'(DEPTH));
  assign accept_c  = req_valid && req_ready;
  assign legal_c   = addr_legal(req_addr, BASE, SIZE);
  assign mem_en    = accept_c && legal_c;
  assign mem_addr  = {req_addr[63:3], 3'b000};

  // Latency pipe; illegal requests take a slot too, keeping responses in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{vld: accept_c, err: !legal_c, hi: req_addr[2]};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign head_c = pipe_q[LATENCY-1];

  // Word select at the pipe head; faulted entries never look at SRAM data.
  always_comb begin
    push_rsp_c = '0;
    if (head_c.err) begin
      push_rsp_c.err = 1'b1;
    end else begin
      push_rsp_c.inst = head_c.hi ? mem_rdata[63:32] : mem_rdata[31:0];
    end
  end

  assign push_c = head_c.vld && (!fifo_full || pop_c);
  assign pop_c  = !fifo_empty && rsp_ready;

  // Credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      case ({accept_c, pop_c})
        2'b10:   credit_q <= credit_q + CRED_W'(1);
        2'b01:   credit_q <= credit_q - CRED_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(DEPTH)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_c),
    .wdata(push_rsp_c),
    .pop  (pop_c),
    .rdata(head_rsp),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_inst  = head_rsp.inst;
  assign rsp_err   = head_rsp.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench: DUT a (LATENCY=1, DEPTH=4) and DUT b (LATENCY=3, DEPTH=8),
// each backed by a fixed-latency SRAM model and an in-order response scoreboard.
module tb_imem_fetch_responder;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned DEP_A = 4;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned DEP_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid_a, req_ready_a, mem_en_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [63:0] req_addr_a, mem_addr_a, mem_rdata_a;
  logic [31:0] rsp_inst_a;

  logic        req_valid_b, req_ready_b, mem_en_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [63:0] req_addr_b, mem_addr_b, mem_rdata_b;
  logic [31:0] rsp_inst_b;

  int total = 0;
  int bad   = 0;

  imem_fetch_responder #(.LATENCY(LAT_A), .DEPTH(DEP_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
    .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_inst(rsp_inst_a), .rsp_err(rsp_err_a)
  );

  imem_fetch_responder #(.LATENCY(LAT_B), .DEPTH(DEP_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_inst(rsp_inst_b), .rsp_err(rsp_err_b)
  );

  // SRAM contents: doubleword 0x8000_0000 is special, elsewhere each word
  // equals its own address.
  function automatic logic [63:0] mem_word(input logic [63:0] dw);
    if (dw == 64'h8000_0000) return 64'hAAAA_BBBB_0000_0013;
    return {dw[31:0] + 32'h4, dw[31:0]};
  endfunction

  // Expected {inst, err} for a fetch PC with the default 128 MiB window.
  function automatic logic [32:0] exp_rsp(input logic [63:0] pc);
    logic [63:0] w;
    if (pc[1:0] != 2'b00 || pc < 64'h8000_0000 || pc >= 64'h8800_0000)
      return {32'h0, 1'b1};
    w = mem_word({pc[63:3], 3'b000});
    return {(pc[2] ? w[63:32] : w[31:0]), 1'b0};
  endfunction

  // SRAM models; they are deliberately not reset so stale data keeps flowing.
  logic        en_a_d [LAT_A];
  logic [63:0] ad_a_d [LAT_A];
  logic        en_b_d [LAT_B];
  logic [63:0] ad_b_d [LAT_B];

  always @(posedge clk) begin
    en_a_d[0] <= mem_en_a;
    ad_a_d[0] <= mem_addr_a;
    for (int i = 1; i < LAT_A; i++) begin
      en_a_d[i] <= en_a_d[i-1];
      ad_a_d[i] <= ad_a_d[i-1];
    end
    en_b_d[0] <= mem_en_b;
    ad_b_d[0] <= mem_addr_b;
    for (int i = 1; i < LAT_B; i++) begin
      en_b_d[i] <= en_b_d[i-1];
      ad_b_d[i] <= ad_b_d[i-1];
    end
  end

  assign mem_rdata_a = (en_a_d[LAT_A-1] === 1'b1) ? mem_word(ad_a_d[LAT_A-1])
                                                  : 64'hDEAD_BEEF_DEAD_BEEF;
  assign mem_rdata_b = (en_b_d[LAT_B-1] === 1'b1) ? mem_word(ad_b_d[LAT_B-1])
                                                  : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  int          acc_a = 0, pop_a = 0, acc_b = 0, pop_b = 0;
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [32:0] held_a = '0, held_b = '0;

  task automatic mon_a();
    if (hold_a) begin
      check("a_hold_valid", rsp_valid_a, 1);
      check("a_hold_data", {rsp_inst_a, rsp_err_a}, held_a);
    end
    if (rsp_valid_a && rsp_ready_a) begin
      if (q_a.size() == 0) check("a_unexpected_rsp", rsp_valid_a, 0);
      else begin
        check("a_rsp_order", {rsp_inst_a, rsp_err_a}, q_a.pop_front());
        pop_a++;
      end
    end
    hold_a = rsp_valid_a && !rsp_ready_a;
    held_a = {rsp_inst_a, rsp_err_a};
    if (req_valid_a && req_ready_a) begin
      q_a.push_back(exp_rsp(req_addr_a));
      acc_a++;
    end
    check("a_credit_bound", (acc_a - pop_a) <= int'(DEP_A), 1);
  endtask

  task automatic mon_b();
    if (hold_b) begin
      check("b_hold_valid", rsp_valid_b, 1);
      check("b_hold_data", {rsp_inst_b, rsp_err_b}, held_b);
    end
    if (rsp_valid_b && rsp_ready_b) begin
      if (q_b.size() == 0) check("b_unexpected_rsp", rsp_valid_b, 0);
      else begin
        check("b_rsp_order", {rsp_inst_b, rsp_err_b}, q_b.pop_front());
        pop_b++;
      end
    end
    hold_b = rsp_valid_b && !rsp_ready_b;
    held_b = {rsp_inst_b, rsp_err_b};
    if (req_valid_b && req_ready_b) begin
      q_b.push_back(exp_rsp(req_addr_b));
      acc_b++;
    end
    check("b_credit_bound", (acc_b - pop_b) <= int'(DEP_B), 1);
  endtask

  task automatic sample();
    @(negedge clk);
    mon_a();
    mon_b();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bad_pc [3];
    logic [63:0] pc;
    int          n;
    int          pops0;

    rst_n = 1'b0;
    req_valid_a = 1'b0; req_addr_a = '0; rsp_ready_a = 1'b0;
    req_valid_b = 1'b0; req_addr_b = '0; rsp_ready_b = 1'b0;

    // Reset state
    repeat (2) begin
      sample();
      check("rst_req_ready_a", req_ready_a, 0);
      check("rst_rsp_valid_a", rsp_valid_a, 0);
      check("rst_rsp_inst_a", rsp_inst_a, 0);
      check("rst_rsp_err_a", rsp_err_a, 0);
      check("rst_req_ready_b", req_ready_b, 0);
      check("rst_rsp_valid_b", rsp_valid_b, 0);
      advance();
    end
    rst_n = 1'b1;
    sample();
    check("post_rst_ready_a", req_ready_a, 1);
    advance();

    // Single legal fetch, low word
    rsp_ready_a = 1'b1;
    req_valid_a = 1'b1; req_addr_a = 64'h8000_0000;
    sample();
    check("t1_mem_en", mem_en_a, 1);
    check("t1_mem_addr", mem_addr_a, 64'h8000_0000);
    advance();
    req_valid_a = 1'b0;
    sample();
    check("t1_not_early", rsp_valid_a, 0);
    advance();
    sample();
    check("t1_rsp_valid", rsp_valid_a, 1);
    check("t1_rsp_inst", rsp_inst_a, 32'h0000_0013);
    check("t1_rsp_err", rsp_err_a, 0);
    advance();

    // Upper word of the same doubleword
    req_valid_a = 1'b1; req_addr_a = 64'h8000_0004;
    sample();
    check("t2_mem_en", mem_en_a, 1);
    check("t2_mem_addr", mem_addr_a, 64'h8000_0000);
    advance();
    req_valid_a = 1'b0;
    sample();
    advance();
    sample();
    check("t2_rsp_valid", rsp_valid_a, 1);
    check("t2_rsp_inst", rsp_inst_a, 32'hAAAA_BBBB);
    check("t2_rsp_err", rsp_err_a, 0);
    advance();
    sample();
    check("t2_empty_valid", rsp_valid_a, 0);
    check("t2_empty_hold", rsp_inst_a, 32'hAAAA_BBBB);
    advance();

    // Misaligned, below window, at window limit
    bad_pc[0] = 64'h8000_0002;
    bad_pc[1] = 64'h7FFF_FFFC;
    bad_pc[2] = 64'h8800_0000;
    for (int k = 0; k < 5; k++) begin
      req_valid_a = (k < 3);
      if (k < 3) req_addr_a = bad_pc[k];
      sample();
      if (k < 3) begin
        check("t3_mem_en", mem_en_a, 0);
        check("t3_ready", req_ready_a, 1);
      end
      if (k >= 2) begin
        check("t3_rsp_valid", rsp_valid_a, 1);
        check("t3_rsp_err", rsp_err_a, 1);
        check("t3_rsp_inst", rsp_inst_a, 0);
      end
      advance();
    end
    req_valid_a = 1'b0;
    sample();
    check("t3_drained", rsp_valid_a, 0);
    advance();

    // Back-pressure: only DEPTH requests fit
    rsp_ready_a = 1'b0;
    pc = 64'h8000_0010;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid_a = (n < 6);
      req_addr_a  = pc;
      sample();
      if (req_valid_a && req_ready_a) begin pc += 4; n++; end
      advance();
    end
    sample();
    check("t4_accepted", n, 4);
    check("t4_ready_low", req_ready_a, 0);
    check("t4_head_valid", rsp_valid_a, 1);
    check("t4_head_inst", rsp_inst_a, 32'h8000_0010);
    advance();
    rsp_ready_a = 1'b1;
    pops0 = pop_a;
    for (int d = 0; d < 12; d++) begin
      req_valid_a = (n < 6);
      req_addr_a  = pc;
      sample();
      if (d < 6) check("t4_drain_valid", rsp_valid_a, 1);
      if (req_valid_a && req_ready_a) begin pc += 4; n++; end
      advance();
    end
    req_valid_a = 1'b0;
    sample();
    check("t4_total_accepted", n, 6);
    check("t4_total_popped", pop_a - pops0, 6);
    check("t4_queue_empty", q_a.size(), 0);
    advance();

    // Streaming at LATENCY=3
    rsp_ready_b = 1'b1;
    pc = 64'h8000_0100;
    for (int c = 0; c < 30; c++) begin
      req_valid_b = 1'b1;
      req_addr_b  = pc;
      sample();
      check("t5_ready", req_ready_b, 1);
      if (c >= 4) check("t5_rsp_valid", rsp_valid_b, 1);
      if (req_valid_b && req_ready_b) pc += 4;
      advance();
    end
    req_valid_b = 1'b0;
    repeat (8) begin sample(); advance(); end
    sample();
    check("t5_acc", acc_b, 30);
    check("t5_balanced", pop_b, acc_b);
    check("t5_queue_empty", q_b.size(), 0);
    advance();

    // Reset with requests both in the pipe and in the FIFO
    rsp_ready_b = 1'b0;
    pc = 64'h8000_0200;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid_b = (n < 4);
      req_addr_b  = pc;
      sample();
      if (req_valid_b && req_ready_b) begin pc += 4; n++; end
      advance();
    end
    req_valid_b = 1'b0;
    sample();
    check("t6_pre_valid", rsp_valid_b, 1);
    check("t6_pre_inst", rsp_inst_b, 32'h8000_0200);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", rsp_valid_b, 0);
    check("t6_async_ready", req_ready_b, 0);
    check("t6_async_inst", rsp_inst_b, 0);
    q_a.delete(); q_b.delete();
    hold_a = 1'b0; hold_b = 1'b0;
    acc_b = 0; pop_b = 0; acc_a = 0; pop_a = 0;
    #1 rst_n = 1'b1;
    advance();
    rsp_ready_b = 1'b1;
    req_valid_b = 1'b1; req_addr_b = 64'h8000_0000;
    sample();
    check("t6_ready", req_ready_b, 1);
    check("t6_mem_en", mem_en_b, 1);
    advance();
    req_valid_b = 1'b0;
    for (int k = 1; k < 4; k++) begin
      sample();
      check("t6_no_stale", rsp_valid_b, 0);
      advance();
    end
    sample();
    check("t6_rsp_valid", rsp_valid_b, 1);
    check("t6_rsp_inst", rsp_inst_b, 32'h0000_0013);
    check("t6_rsp_err", rsp_err_b, 0);
    advance();
    repeat (3) begin
      sample();
      check("t6_quiet", rsp_valid_b, 0);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Memory-side responder for the fetch PC stream. The fetch unit issues an instruction address, and this block returns the 32-bit instruction word.
- Sits between the fetch unit and a 64-bit-wide instruction SRAM with fixed read latency.
- Accepts requests with a valid/ready handshake and returns in-order responses through a credit-limited response FIFO.
- Flags misaligned or out-of-range PCs without touching memory.

Parameters:
- LATENCY, 1, SRAM read latency in cycles from mem_en to mem_rdata valid (>=1).
- DEPTH, 4, response FIFO entries and maximum outstanding requests (power of 2, >=2).
- BASE, 64'h8000_0000, first legal instruction address (matches the PC reset value).
- SIZE, 64'h0800_0000, legal window size in bytes; legal range is [BASE, BASE+SIZE).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  fetch PC.
- mem_en  out  1  SRAM read strobe.
- mem_addr  out  64  SRAM doubleword address, {req_addr[63:3],3'b000}.
- mem_rdata  in  64  SRAM read data, valid exactly LATENCY cycles after mem_en.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_inst  out  32  instruction word.
- rsp_err  out  1  access fault: misaligned or out of range.

Behaviour:
- Reset (rst_n low, asynchronous): req_ready=0 while asserted, rsp_valid=0, rsp_inst=0, rsp_err=0, credit=0, FIFO empty, latency pipe cleared. All in-flight requests are dropped; SRAM data returning after reset is ignored.
- Accept: a request is accepted when req_valid && req_ready in cycle T.
- req_ready = rst_n && (credit < DEPTH), where credit = in-flight requests + FIFO occupancy.
- Credit update per cycle: +1 on accept, -1 on response pop; both in the same cycle leaves credit unchanged.
- Legal request: req_addr[1:0]==0 and BASE <= req_addr < BASE+SIZE. Use 64-bit unsigned compares; BASE+SIZE must not wrap.
- Legal accept: mem_en=1 in cycle T, driven combinationally from the handshake.
- Illegal accept: mem_en=0 and the SRAM is not accessed. The request still occupies a credit and a pipe slot, so response order is preserved.
- Latency pipe: LATENCY stages carrying {valid, err, hi=req_addr[2]}, advancing every cycle with no stall. Stall-free operation is guaranteed by the credit limit.
- At T+LATENCY, the pipe head is pushed into the FIFO:
  - inst = hi ? mem_rdata[63:32] : mem_rdata[31:0], err=0.
  - For an err entry: inst=32'h0, err=1, mem_rdata ignored.
- Response: rsp_valid/rsp_inst/rsp_err come from the registered FIFO head. The earliest rsp_valid is cycle T+LATENCY+1, so back-to-back throughput is one response per cycle.
- rsp_valid must stay asserted and rsp_inst/rsp_err must stay stable until rsp_ready is sampled high.
- Full FIFO: a push is guaranteed never to overflow by credit. A simultaneous push and pop at occupancy DEPTH is legal.
- Empty FIFO: rsp_valid=0 and rsp_inst/rsp_err hold their last value, with no X.
- Pointers wrap modulo DEPTH, with an extra MSB for the full/empty distinction.
- req_addr and req_valid are ignored when req_ready=0.

Decomposition:
- Shared package, imem_pkg:
  - typedef pipe_tag_t {logic vld; logic err; logic hi;}.
  - typedef rsp_t {logic [31:0] inst; logic err;}.
  - localparam PC_RESET=64'h8000_0000.
  - Helper function addr_legal(addr, base, size).
- Natural sub-module: sync_fifo (parameterised WIDTH/DEPTH, push/pop, full/empty, count) holding rsp_t.
- The latency pipe and credit counter stay in the top module.

Test Plan:
- Reset release, then a single request with req_addr=64'h8000_0000, LATENCY=1, mem_rdata=64'hAAAA_BBBB_0000_0013 -> mem_en=1 and mem_addr=64'h8000_0000 in T; rsp_valid in T+2 with rsp_inst=32'h0000_0013, rsp_err=0.
- req_addr=64'h8000_0004, same mem_rdata -> rsp_inst=32'hAAAA_BBBB; mem_addr=64'h8000_0000.
- req_addr=64'h8000_0002, then req_addr=64'h7FFF_FFFC, then req_addr=64'h8800_0000 -> mem_en=0 for all three; three responses in order, each with rsp_err=1, rsp_inst=0.
- rsp_ready=0, stream of 6 legal requests, DEPTH=4 -> exactly 4 accepted, req_ready=0 afterwards. Raise rsp_ready -> one response per cycle in PC order; remaining requests accepted as credits free; no loss or duplication.
- Continuous req_valid with rsp_ready=1 at LATENCY=3 -> steady state of one accept and one response per cycle; credit never exceeds DEPTH.
- rst_n pulsed low with 2 in flight and 2 in the FIFO -> rsp_valid=0 immediately (asynchronous); after release, first request at 64'h8000_0000 returns the correct word; stale mem_rdata never appears at the response.
